max_pool_multi: RTL and testbench
=================================

Name: max_pool_multi

Overview:
- Sequential 2x2 / stride-2 max-pooling stage directly downstream of the multi-filter convolution layer.
- Consumes the flat K-map convolution result bus (maps of H x W, 8-bit signed), latches it on start, and emits one pooled value per cycle into a flat output bus.
- Completion is signalled with a done pulse for the next layer or a dense stage.

Parameters:
- DATA_WIDTH, 8, element width, two's complement signed.
- K, 6, number of feature maps; matches the filter count of the conv layer.
- H, 6, input map height; equals conv output height (8-3+1).
- W, 6, input map width.
- PH, H/2, derived localparam: pooled height (floor).
- PW, W/2, derived localparam: pooled width (floor).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-low reset.
- start, input, 1, request to pool the current in_maps contents.
- in_maps, input, K*H*W*DATA_WIDTH, flat bus ordered map, row, col; element 0 occupies the MSBs ([0:...] ascending indexing).
- busy, output, 1, high while a pooling pass is running.
- done, output, 1, single-cycle completion pulse.
- out_pool, output, K*PH*PW*DATA_WIDTH, flat pooled result, same ordering and indexing convention as in_maps.

Behaviour:
- Reset, sampled at posedge while reset==0: state=IDLE, busy=0, done=0, out_pool=0, all counters=0, latched input register=0. This applies in any state, including mid-pass; any partial result is discarded.
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - start==1 at an edge: latch in_maps into an internal register, clear the k/r/c counters, go to RUN, busy=1.
  - start==0: hold; out_pool retains its last values.
- RUN: each cycle, compute window (k, r, c) from the latched copy.
  - Elements used: [k][2r][2c], [k][2r][2c+1], [k][2r+1][2c], [k][2r+1][2c+1].
  - The signed maximum is written at out_pool index k*PH*PW + r*PW + c on the edge.
  - Counter order: c fastest, then r, then k.
  - c wraps PW-1 -> 0 and increments r; r wraps PH-1 -> 0 and increments k.
- Last window (k=K-1, r=PH-1, c=PW-1): written on the edge that also moves state to DONE.
- DONE: done=1, busy=0 for exactly one cycle, then IDLE unconditionally.
- Latency: start sampled at edge t0 -> window i written at edge t0+1+i (i = 0..K*PH*PW-1) -> done high in the cycle after edge t0+K*PH*PW. Defaults: 54 windows, done after edge t0+54.
- start while in RUN or DONE: ignored, with no queueing. in_maps changes after the latch edge have no effect on the running pass.
- Odd H or W: the last row/column is dropped (floor), never padded.
- Arithmetic: comparison is signed, DATA_WIDTH bits, with no widening. Ties select either operand (values are equal).
- A new pass overwrites out_pool element by element. Elements not yet rewritten keep the previous pass's values until overwritten.

Optional Feature:
- Macro: MAX_POOL_RELU_EN.
- Defined: each pooled max is clamped to 0 when its sign bit is 1 (fused ReLU) before being written.
- Undefined: the raw signed max is written, so negative results pass through unchanged.
- Timing and handshake are identical in both builds.

Decomposition:
- Shared package cnn_pkg holds:
  - DATA_WIDTH default.
  - The pooled-size function (n/2).
  - The state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - A signed max2 function.
- Sub-module pool_window_max: combinational 4-input signed max tree. It contains the MAX_POOL_RELU_EN clamp, so the top module holds only the FSM, counters, input latch and output write.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles with start=1 -> busy=0, done=0, out_pool all zero; release with start=0 -> stays IDLE.
- Basic pass: K=6, map 0 elements = row*6+col (0..35), other maps zero.
  - out_pool map 0 = {7,9,11,19,21,23,31,33,35}.
  - done pulses exactly once, in the cycle after edge t0+54.
  - busy is high for 54 cycles.
- Signed/ReLU: a window holding {-5,-3,-128,-1} gives -1 without the macro and 0 with MAX_POOL_RELU_EN. A window holding {-128,127,0,5} gives 127 in both builds.
- Input stability and start-ignore:
  - Change in_maps to all 8'h7F one cycle after start -> results match the originally latched data.
  - Pulse start at edge t0+20 -> no restart, done still follows edge t0+54.
- Reset mid-pass: drive reset=0 at edge t0+10 -> next cycle busy=0, out_pool=0, state IDLE. A subsequent start produces a full correct pass.
- Odd size: H=W=5, K=1, elements = index 0..24 -> PH=PW=2, out_pool={6,8,16,18}, done after 4 windows.

Source files
------------

// File: rtl/max_pool_multi_pkg.sv
// Shared CNN definitions (package cnn_pkg): default element width, pooled-size helper,
// pooling FSM state encoding and a signed max helper.
package cnn_pkg;

  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Odd sizes drop the trailing row/column.
  function automatic int pooled_size(input int n);
    return n / 2;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/max_pool_multi_if.sv
// Pooling stage port bundle: request/data from the conv layer, status and pooled
// result back, plus the FSM state for observation.
interface max_pool_multi_if #(
    parameter int DATA_WIDTH = cnn_pkg::DEF_DATA_WIDTH,
    parameter int K          = 6,
    parameter int H          = 6,
    parameter int W          = 6
);
    import cnn_pkg::*;

    localparam int PH = pooled_size(H);
    localparam int PW = pooled_size(W);

    // Handshake: start is a request sampled only while the stage is idle (busy=0, done=0);
    // in_maps is captured on that same edge. Requests while busy or done are dropped.
    // done is a one-cycle pulse, after which out_pool holds the complete result.
    logic                           start;
    logic [K*H*W*DATA_WIDTH-1:0]    in_maps;
    logic                           busy;
    logic                           done;
    logic [K*PH*PW*DATA_WIDTH-1:0]  out_pool;
    state_t                         state;

    modport master (output start, in_maps, input busy, done, out_pool, state);
    modport slave  (input start, in_maps, output busy, done, out_pool, state);
endinterface

// File: rtl/max_pool_multi_window.sv
// pool_window_max: combinational signed max of one 2x2 window.
// Define MAX_POOL_RELU_EN to clamp negative maxima to zero (fused ReLU).
module pool_window_max
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    input  logic signed [DATA_WIDTH-1:0] c,
    input  logic signed [DATA_WIDTH-1:0] d,
    output logic        [DATA_WIDTH-1:0] max_val
);
    int m;

    // Sign extension preserves ordering, so the result equals a DATA_WIDTH signed compare.
    always_comb begin
        m = max2(max2(int'(a), int'(b)), max2(int'(c), int'(d)));
`ifdef MAX_POOL_RELU_EN
        if (m < 0) m = 0;
`endif
        max_val = DATA_WIDTH'(m);
    end
endmodule

// File: rtl/max_pool_multi.sv
// 2x2 / stride-2 max-pooling over K latched feature maps, one window per cycle.
// Optional fused ReLU in pool_window_max via MAX_POOL_RELU_EN.
module max_pool_multi
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int K          = 6,
    parameter int H          = 6,
    parameter int W          = 6
) (
    input  logic             clk,
    input  logic             reset,
    max_pool_multi_if.slave  bus
);
    localparam int PH   = pooled_size(H);
    localparam int PW   = pooled_size(W);
    localparam int NIN  = K * H * W;
    localparam int NOUT = K * PH * PW;
    localparam int KB   = (K  > 1) ? $clog2(K)  : 1;
    localparam int RB   = (PH > 1) ? $clog2(PH) : 1;
    localparam int CB   = (PW > 1) ? $clog2(PW) : 1;
    localparam logic [KB-1:0] K_LAST = KB'(K - 1);
    localparam logic [RB-1:0] R_LAST = RB'(PH - 1);
    localparam logic [CB-1:0] C_LAST = CB'(PW - 1);

    state_t                     state_q, state_d;
    logic [NIN*DATA_WIDTH-1:0]  maps_q;
    logic [NOUT*DATA_WIDTH-1:0] pool_q;
    logic [KB-1:0]              k_q;
    logic [RB-1:0]              r_q;
    logic [CB-1:0]              c_q;
    logic signed [DATA_WIDTH-1:0] e00, e01, e10, e11;
    logic [DATA_WIDTH-1:0]      win_max;
    logic                       last_win;
    int                         out_idx;

    // Element 0 sits in the MSBs of the flat buses.
    always_comb begin
        int base;
        base    = int'(k_q) * H * W + 2 * int'(r_q) * W + 2 * int'(c_q);
        out_idx = int'(k_q) * PH * PW + int'(r_q) * PW + int'(c_q);
        e00 = maps_q[(NIN - 1 - base)         * DATA_WIDTH +: DATA_WIDTH];
        e01 = maps_q[(NIN - 1 - (base + 1))     * DATA_WIDTH +: DATA_WIDTH];
        e10 = maps_q[(NIN - 1 - (base + W))     * DATA_WIDTH +: DATA_WIDTH];
        e11 = maps_q[(NIN - 1 - (base + W + 1)) * DATA_WIDTH +: DATA_WIDTH];
    end

    pool_window_max #(.DATA_WIDTH(DATA_WIDTH)) u_window (
        .a(e00), .b(e01), .c(e10), .d(e11), .max_val(win_max)
    );

    assign last_win = (k_q == K_LAST) && (r_q == R_LAST) && (c_q == C_LAST);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_win)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            maps_q  <= '0;
            pool_q  <= '0;
            k_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        maps_q <= bus.in_maps;
                        k_q    <= '0;
                        r_q    <= '0;
                        c_q    <= '0;
                    end
                end
                RUN: begin
                    pool_q[(NOUT - 1 - out_idx) * DATA_WIDTH +: DATA_WIDTH] <= win_max;
                    // c fastest, then r, then k
                    if (c_q == C_LAST) begin
                        c_q <= '0;
                        if (r_q == R_LAST) begin
                            r_q <= '0;
                            k_q <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
                        end else begin
                            r_q <= r_q + 1'b1;
                        end
                    end else begin
                        c_q <= c_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.out_pool = pool_q;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_max_pool_multi.sv
// Self-checking bench for max_pool_multi: 6x6x6 main instance plus a 1x5x5 odd-size instance,
// checked against a 2x2 max reference model (honours MAX_POOL_RELU_EN).
module tb_max_pool_multi;
  import cnn_pkg::*;

  localparam int DW   = 8;
  localparam int K    = 6;
  localparam int H    = 6;
  localparam int W    = 6;
  localparam int PH   = H / 2;
  localparam int PW   = W / 2;
  localparam int NIN  = K * H * W;
  localparam int NOUT = K * PH * PW;
  localparam int NIN2  = 25;
  localparam int NOUT2 = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  max_pool_multi_if #(.DATA_WIDTH(DW), .K(K), .H(H), .W(W)) bus ();
  max_pool_multi_if #(.DATA_WIDTH(DW), .K(1), .H(5), .W(5))  bus2 ();

  max_pool_multi #(.DATA_WIDTH(DW), .K(K), .H(H), .W(W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  max_pool_multi #(.DATA_WIDTH(DW), .K(1), .H(5), .W(5)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  // ---------------- scoreboard state ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  int img [NIN];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_full [NOUT];

  function automatic logic [DW-1:0] out_el(input int o);
    return bus.out_pool[(NOUT - 1 - o) * DW +: DW];
  endfunction

  function automatic logic [DW-1:0] out_el2(input int o);
    return bus2.out_pool[(NOUT2 - 1 - o) * DW +: DW];
  endfunction

  // Reference: plain max over each 2x2 block, in output order.
  task automatic build_expected();
    int m, v;
    logic [31:0] t;
    exp_q.delete();
    for (int k = 0; k < K; k++)
      for (int r = 0; r < PH; r++)
        for (int c = 0; c < PW; c++) begin
          m = img[k*H*W + (2*r)*W + 2*c];
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
              v = img[k*H*W + (2*r+dr)*W + 2*c+dc];
              if (v > m) m = v;
            end
`ifdef MAX_POOL_RELU_EN
          if (m < 0) m = 0;
`endif
          t = m;
          exp_q.push_back(t[DW-1:0]);
          exp_full[k*PH*PW + r*PW + c] = t[DW-1:0];
        end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_image();
    logic [31:0] v;
    for (int e = 0; e < NIN; e++) begin
      v = img[e];
      bus.in_maps[(NIN - 1 - e) * DW +: DW] = v[DW-1:0];
    end
  endtask

  task automatic random_image();
    for (int e = 0; e < NIN; e++) img[e] = int'($urandom_range(0, 255)) - 128;
  endtask

  // Runs one full pass of img; checks each window on its write edge, busy/done timing
  // and the final bus. Optionally scrambles in_maps after the latch and pokes start mid-pass.
  task automatic run_pass(input string name, input bit change_after, input bit restart_mid);
    logic [DW-1:0] got, exp;
    logic [NOUT*DW-1:0] exp_bus;
    int busy_cnt, done_cnt;
    busy_cnt = 0;
    done_cnt = 0;
    build_expected();
    @(negedge clk);
    drive_image();
    bus.start = 1'b1;
    @(posedge clk);  // t0
    #1;
    if (bus.busy) busy_cnt++;
    total_cnt++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) $display("FAIL %s busy_after_start: busy=%b done=%b expected 1/0", name, bus.busy, bus.done);
    else pass_cnt++;
    @(negedge clk);
    bus.start = 1'b0;
    if (change_after) for (int e = 0; e < NIN; e++) bus.in_maps[e*DW +: DW] = 8'h7F;
    for (int j = 1; j <= NOUT + 1; j++) begin
      @(posedge clk);
      #1;
      if (bus.busy) busy_cnt++;
      if (bus.done) done_cnt++;
      if (j <= NOUT) begin
        exp = exp_q.pop_front();
        got = out_el(j - 1);
        total_cnt++;
        if (got !== exp) $display("FAIL %s win%0d: got %0d expected %0d", name, j - 1, $signed(got), $signed(exp));
        else pass_cnt++;
      end
      total_cnt++;
      if (bus.done !== (j == NOUT) || bus.busy !== (j < NOUT))
        $display("FAIL %s timing edge t0+%0d: busy=%b done=%b expected %b/%b", name, j, bus.busy, bus.done, j < NOUT, j == NOUT);
      else pass_cnt++;
      @(negedge clk);
      bus.start = (restart_mid && j == 19) ? 1'b1 : 1'b0;
    end
    total_cnt++;
    if (busy_cnt !== NOUT) $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, NOUT);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt !== 1) $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
    else pass_cnt++;
    for (int o = 0; o < NOUT; o++) exp_bus[(NOUT - 1 - o) * DW +: DW] = exp_full[o];
    total_cnt++;
    if (bus.out_pool !== exp_bus) $display("FAIL %s final_bus: got %h expected %h", name, bus.out_pool, exp_bus);
    else pass_cnt++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b1;
    bus.in_maps = {NIN*DW/32{$urandom}};
    bus2.start = 1'b1;
    bus2.in_maps = '1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL reset_status: busy=%b done=%b expected 0/0", bus.busy, bus.done);
    else pass_cnt++;
    total_cnt++;
    if (bus.out_pool !== '0 || bus2.out_pool !== '0) $display("FAIL reset_out_pool: got %h / %h expected zero", bus.out_pool, bus2.out_pool);
    else pass_cnt++;
    total_cnt++;
    if (bus.state !== IDLE) $display("FAIL reset_state: got %0d expected %0d", bus.state, IDLE);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    bus.start = 1'b0;
    bus2.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.state !== IDLE || bus.busy !== 1'b0 || bus2.busy !== 1'b0)
      $display("FAIL idle_hold: state=%0d busy=%b busy2=%b expected IDLE/0/0", bus.state, bus.busy, bus2.busy);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int exp_m0 [9] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
    for (int e = 0; e < NIN; e++) img[e] = (e < H*W) ? e : 0;
    run_pass("basic", 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      total_cnt++;
      if (out_el(i) !== exp_m0[i][DW-1:0]) $display("FAIL basic_map0[%0d]: got %0d expected %0d", i, out_el(i), exp_m0[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_signed();
    logic [DW-1:0] exp_neg;
    random_image();
    img[72] = -5;    img[73] = -3;  img[78] = -128; img[79] = -1;
    img[122] = -128; img[123] = 127; img[128] = 0;   img[129] = 5;
`ifdef MAX_POOL_RELU_EN
    exp_neg = 8'h00;
`else
    exp_neg = 8'hFF;
`endif
    run_pass("signed", 1'b0, 1'b0);
    total_cnt++;
    if (out_el(18) !== exp_neg) $display("FAIL signed_neg_window: got %h expected %h", out_el(18), exp_neg);
    else pass_cnt++;
    total_cnt++;
    if (out_el(31) !== 8'h7F) $display("FAIL signed_mixed_window: got %h expected 7f", out_el(31));
    else pass_cnt++;
  endtask

  task automatic test_stability_restart();
    random_image();
    run_pass("stable_restart", 1'b1, 1'b1);
    random_image();
    run_pass("back_to_back", 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    random_image();
    @(negedge clk);
    drive_image();
    bus.start = 1'b1;
    @(posedge clk);  // t0
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(posedge clk);  // t0+9
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);  // t0+10
    #1;
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.state !== IDLE)
      $display("FAIL midreset_status: busy=%b done=%b state=%0d expected 0/0/IDLE", bus.busy, bus.done, bus.state);
    else pass_cnt++;
    total_cnt++;
    if (bus.out_pool !== '0) $display("FAIL midreset_out_pool: got %h expected zero", bus.out_pool);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    random_image();
    run_pass("after_reset", 1'b0, 1'b0);
  endtask

  task automatic test_odd_size();
    logic [DW-1:0] exp_o [NOUT2];
    logic [31:0] v;
    exp_o = '{8'd6, 8'd8, 8'd16, 8'd18};
    @(negedge clk);
    for (int e = 0; e < NIN2; e++) begin
      v = e;
      bus2.in_maps[(NIN2 - 1 - e) * DW +: DW] = v[DW-1:0];
    end
    bus2.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus2.start = 1'b0;
    for (int j = 1; j <= NOUT2 + 1; j++) begin
      @(posedge clk);
      #1;
      if (j <= NOUT2) begin
        total_cnt++;
        if (out_el2(j - 1) !== exp_o[j - 1]) $display("FAIL odd_win%0d: got %0d expected %0d", j - 1, out_el2(j - 1), exp_o[j - 1]);
        else pass_cnt++;
      end
      total_cnt++;
      if (bus2.done !== (j == NOUT2) || bus2.busy !== (j < NOUT2))
        $display("FAIL odd_timing edge t0+%0d: busy=%b done=%b expected %b/%b", j, bus2.busy, bus2.done, j < NOUT2, j == NOUT2);
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_stability_restart();
    test_reset_mid();
    test_odd_size();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
